// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters.
// Define ALU_ARB_FIXED_PRIO_EN to make ties always go to requester 0.
module alu_share_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [OP_WIDTH-1:0]   req0_op,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_b,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [OP_WIDTH-1:0]   req1_op,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_b,
  output logic                  resp0_valid,
  input  logic                  resp0_ready,
  output logic [DATA_WIDTH-1:0] resp0_data,
  output logic                  resp1_valid,
  input  logic                  resp1_ready,
  output logic [DATA_WIDTH-1:0] resp1_data,
  output logic [OP_WIDTH-1:0]   alu_op,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  input  logic [DATA_WIDTH-1:0] alu_result,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  state_t                state, state_next;
  logic [OP_WIDTH-1:0]   op_r;
  logic [DATA_WIDTH-1:0] a_r, b_r, res_r;
  logic                  owner, last_grant;
  logic                  grant;
  logic                  accept;
  logic                  resp_done;

  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      grant = 1'b0;
`else
      grant = ~last_grant;
`endif
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  assign accept    = (state == IDLE) && (req0_valid || req1_valid);
  assign resp_done = (state == HOLD) && (owner ? resp1_ready : resp0_ready);

  // Readies are forced low while reset is asserted, even though state already reads IDLE.
  assign req0_ready = rst_n && (state == IDLE) && req0_valid && !grant;
  assign req1_ready = rst_n && (state == IDLE) && req1_valid && grant;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    state_next = HOLD;
      HOLD:    if (resp_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_r       <= '0;
      a_r        <= '0;
      b_r        <= '0;
      res_r      <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state <= state_next;
      if (accept) begin
        owner <= grant;
        op_r  <= grant ? req1_op : req0_op;
        a_r   <= grant ? req1_a  : req0_a;
        b_r   <= grant ? req1_b  : req0_b;
      end
      if (state == EXEC) res_r <= alu_result;
      if (resp_done) last_grant <= owner;
    end
  end

  assign alu_op      = op_r;
  assign alu_a       = a_r;
  assign alu_b       = b_r;
  assign resp0_valid = (state == HOLD) && !owner;
  assign resp1_valid = (state == HOLD) && owner;
  assign resp0_data  = res_r;
  assign resp1_data  = res_r;
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small ADD/SUB ALU model.
// Expected tie grants follow ALU_ARB_FIXED_PRIO_EN when it is defined.
module tb_alu_share_arbiter;

  localparam logic [3:0] ADD = 4'b1011;
  localparam logic [3:0] SUB = 4'b1010;

  logic        clk, rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]  req0_op, req1_op, alu_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        resp0_valid, resp0_ready, resp1_valid, resp1_ready;
  logic [31:0] resp0_data, resp1_data, alu_a, alu_b, alu_result;
  logic        busy;

  int checks = 0;
  int failures = 0;

  alu_share_arbiter #(.DATA_WIDTH(32), .OP_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_data(resp0_data),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_data(resp1_data),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .busy(busy)
  );

  assign alu_result = (alu_op == ADD) ? alu_a + alu_b :
                      (alu_op == SUB) ? alu_a - alu_b : 32'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic exp_g, g;
    logic [31:0] exp_d;
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_op = ADD; req0_a = 32'd0; req0_b = 32'd0;
    req1_valid = 1'b1; req1_op = SUB; req1_a = 32'd0; req1_b = 32'd0;
    resp0_ready = 1'b0; resp1_ready = 1'b0;

    // Reset state, with both requesters valid during reset
    @(negedge clk); @(negedge clk); #1;
    chk1("rst_req0_ready", req0_ready, 1'b0);
    chk1("rst_req1_ready", req1_ready, 1'b0);
    chk1("rst_resp0_valid", resp0_valid, 1'b0);
    chk1("rst_resp1_valid", resp1_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk32("rst_alu_op", {28'd0, alu_op}, 32'd0);
    chk32("rst_alu_a", alu_a, 32'd0);
    chk32("rst_resp0_data", resp0_data, 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Single request: ADD 5+7
    req0_valid = 1'b1; req0_op = ADD; req0_a = 32'd5; req0_b = 32'd7; #1;
    chk1("single_req0_ready", req0_ready, 1'b1);
    chk1("single_req1_ready", req1_ready, 1'b0);
    @(negedge clk); req0_valid = 1'b0; #1;
    chk1("single_exec_busy", busy, 1'b1);
    chk32("single_alu_op", {28'd0, alu_op}, {28'd0, ADD});
    chk32("single_alu_a", alu_a, 32'd5);
    chk32("single_alu_b", alu_b, 32'd7);
    chk1("single_exec_resp0_valid", resp0_valid, 1'b0);
    @(negedge clk); #1;
    chk1("single_resp0_valid", resp0_valid, 1'b1);
    chk32("single_resp0_data", resp0_data, 32'd12);
    chk1("single_resp1_valid", resp1_valid, 1'b0);
    resp0_ready = 1'b1;
    @(negedge clk); resp0_ready = 1'b0; #1;
    chk1("single_idle_busy", busy, 1'b0);
    chk1("single_done_resp0_valid", resp0_valid, 1'b0);

    // Tie after reset goes to requester 0, then requester 1 is served
    pulse_reset();
    req0_valid = 1'b1; req0_op = ADD; req0_a = 32'd1; req0_b = 32'd1;
    req1_valid = 1'b1; req1_op = SUB; req1_a = 32'd9; req1_b = 32'd4; #1;
    chk1("tie_req0_ready", req0_ready, 1'b1);
    chk1("tie_req1_ready", req1_ready, 1'b0);
    @(negedge clk); req0_valid = 1'b0; #1;
    chk1("tie_exec_req1_wait", req1_ready, 1'b0);
    @(negedge clk); #1;
    chk1("tie_resp0_valid", resp0_valid, 1'b1);
    chk32("tie_resp0_data", resp0_data, 32'd2);
    chk1("tie_hold_req1_wait", req1_ready, 1'b0);
    resp0_ready = 1'b1;
    @(negedge clk); resp0_ready = 1'b0; #1;
    chk1("tie_req1_granted", req1_ready, 1'b1);
    @(negedge clk);
    @(negedge clk);
    req0_valid = 1'b1; req0_op = ADD; req0_a = 32'd1; req0_b = 32'd1;

    // Backpressure: resp1_ready low for 10 cycles while req0 waits
    for (int i = 0; i < 10; i++) begin
      #1;
      chk1("bp_resp1_valid", resp1_valid, 1'b1);
      chk32("bp_resp1_data", resp1_data, 32'd5);
      chk1("bp_busy", busy, 1'b1);
      chk1("bp_req0_ready", req0_ready, 1'b0);
      @(negedge clk);
    end
    resp1_ready = 1'b1;
    @(negedge clk);
    resp1_ready = 1'b0;
    req1_valid = 1'b1; req1_op = SUB; req1_a = 32'd9; req1_b = 32'd4; #1;
    chk1("bp_release_busy", busy, 1'b0);
    chk1("bp_release_resp1_valid", resp1_valid, 1'b0);
    chk1("retie_req0_ready", req0_ready, 1'b1);
    chk1("retie_req1_ready", req1_ready, 1'b0);
    @(negedge clk); req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk); #1;
    chk32("retie_resp0_data", resp0_data, 32'd2);
    resp0_ready = 1'b1;
    @(negedge clk); resp0_ready = 1'b0;

    // Both requesters continuously valid for 4 operations
    pulse_reset();
    for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp_g = 1'b0;
`else
      exp_g = (k % 2 == 1);
`endif
      req0_valid = 1'b1; req0_op = ADD; req0_a = 32'(k); req0_b = 32'd10;
      req1_valid = 1'b1; req1_op = SUB; req1_a = 32'd100; req1_b = 32'(k);
      #1;
      g = req1_ready;
      chk1("rr_one_ready", req0_ready ^ req1_ready, 1'b1);
      chk1("rr_grant", g, exp_g);
      exp_d = exp_g ? 32'(100 - k) : 32'(k + 10);
      @(negedge clk);
      @(negedge clk); #1;
      chk1("rr_resp_valid", exp_g ? resp1_valid : resp0_valid, 1'b1);
      chk32("rr_resp_data", exp_g ? resp1_data : resp0_data, exp_d);
      resp0_ready = 1'b1; resp1_ready = 1'b1;
      @(negedge clk);
      resp0_ready = 1'b0; resp1_ready = 1'b0;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Wrap-around results
    req1_valid = 1'b1; req1_op = SUB; req1_a = 32'd0; req1_b = 32'd1; #1;
    chk1("wrap_sub_ready", req1_ready, 1'b1);
    @(negedge clk); req1_valid = 1'b0;
    @(negedge clk); #1;
    chk1("wrap_sub_valid", resp1_valid, 1'b1);
    chk32("wrap_sub_data", resp1_data, 32'hFFFF_FFFF);
    resp1_ready = 1'b1;
    @(negedge clk); resp1_ready = 1'b0;
    req0_valid = 1'b1; req0_op = ADD; req0_a = 32'hFFFF_FFFF; req0_b = 32'd1; #1;
    chk1("wrap_add_ready", req0_ready, 1'b1);
    @(negedge clk); req0_valid = 1'b0;
    @(negedge clk); #1;
    chk1("wrap_add_valid", resp0_valid, 1'b1);
    chk32("wrap_add_data", resp0_data, 32'd0);
    resp0_ready = 1'b1;
    @(negedge clk); resp0_ready = 1'b0;

    // Reset during EXEC discards the operation
    req0_valid = 1'b1; req0_op = ADD; req0_a = 32'd3; req0_b = 32'd4;
    @(negedge clk); req0_valid = 1'b0; #1;
    chk1("mid_exec_busy", busy, 1'b1);
    rst_n = 1'b0; #1;
    chk1("mid_rst_busy", busy, 1'b0);
    chk32("mid_rst_alu_op", {28'd0, alu_op}, 32'd0);
    chk32("mid_rst_alu_a", alu_a, 32'd0);
    chk32("mid_rst_alu_b", alu_b, 32'd0);
    chk1("mid_rst_resp0_valid", resp0_valid, 1'b0);
    chk1("mid_rst_req0_ready", req0_ready, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    chk1("post_rst_resp0_valid", resp0_valid, 1'b0);
    chk1("post_rst_busy", busy, 1'b0);
    req0_valid = 1'b1; req1_valid = 1'b1; #1;
    chk1("post_rst_tie_req0", req0_ready, 1'b1);
    chk1("post_rst_tie_req1", req1_ready, 1'b0);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Shares the single combinational ALU between two requesters: requester 0 is the execute stage and requester 1 is the address/branch helper. It accepts one request at a time with round-robin arbitration, registers the operands and the 4-bit Operation code onto the ALU inputs, captures the result, and returns it on a per-requester valid/ready response channel. It sits between the `ALUController`/operand muxes and the ALU instance.

## Interface
- DATA_WIDTH, 32, operand/result width
- OP_WIDTH, 4, ALU Operation code width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_op / req1_op  in  OP_WIDTH  ALU Operation code
- req0_a, req0_b / req1_a, req1_b  in  DATA_WIDTH  operands
- resp0_valid / resp1_valid  out  1  result available
- resp0_ready / resp1_ready  in  1  requester takes result
- resp0_data / resp1_data  out  DATA_WIDTH  result
- alu_op  out  OP_WIDTH  to ALU Operation input
- alu_a, alu_b  out  DATA_WIDTH  to ALU operands
- alu_result  in  DATA_WIDTH  from ALU, combinational
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, EXEC, HOLD. Registers: op_r, a_r, b_r, res_r, owner (1 bit), last_grant (1 bit).
- IDLE:
  - grant = the only valid requester.
  - If both requesters are valid, grant = !last_grant.
  - reqN_ready = (state==IDLE) && reqN_valid && grant==N. At most one ready is high.
  - On accept, latch op/a/b into op_r/a_r/b_r, set owner=grant, and go to EXEC.
- EXEC: lasts one cycle. res_r <= alu_result. Go to HOLD.
- HOLD:
  - resp[owner]_valid=1 and resp[owner]_data=res_r. The other resp_valid is 0.
  - When resp[owner]_ready is high, set last_grant<=owner and go to IDLE.
- alu_op/alu_a/alu_b are driven from op_r/a_r/b_r at all times. They are stable from EXEC through HOLD.
- respN_data is valid only while respN_valid is high. It holds res_r otherwise.
- Protocol rules, checked by bench assertions:
  - reqN_valid and the payload must stay stable until ready.
  - A requester whose response is pending is not accepted again until its response completes.

## Timing
- Accept in cycle T. ALU evaluates in T+1. resp_valid is high from T+2.
- Minimum turnaround is 3 cycles per operation. The next accept can happen in the cycle after the response handshake.
- Reset (rst_n low, any state, including mid-EXEC/HOLD): state=IDLE, all req_ready=0, all resp_valid=0, op_r=0, a_r=0, b_r=0, res_r=0, owner=0, last_grant=1. Any in-flight result is discarded.
- First tie after reset goes to requester 0.
- A request arriving during EXEC/HOLD waits. Its ready stays 0.
- A resp_ready held low stalls in HOLD indefinitely, with resp_data stable.
- resp_ready high during IDLE/EXEC is ignored.

## Configuration
- ALU_ARB_FIXED_PRIO_EN defined:
  - Ties always grant requester 0.
  - last_grant is still maintained but unused.
  - Requester 1 can starve; this is accepted for single-issue builds.
- Undefined (default): round-robin as above. With both requesters continuously valid, grants alternate 0,1,0,1.

## Test plan
- Bench ALU model implements ADD=4'b1011 and SUB=4'b1010.
- Single request: req0 ADD a=5, b=7 accepted at T -> alu_op=4'b1011 at T+1 -> resp0_valid with data 12 at T+2, and resp1_valid stays 0.
- Tie after reset: req0 ADD 1+1 and req1 SUB 9-4 both valid -> req0 granted first (resp0_data=2). After the handshake, req1 is granted (resp1_data=5). Then a repeat tie grants req0.
- Backpressure: resp1_ready held low for 10 cycles -> resp1_valid and resp1_data=5 remain stable, busy=1, req0_ready=0. Release -> IDLE the next cycle.
- Reset mid-operation: rst_n low during EXEC -> resp valids, readies and alu_* read 0 immediately (asynchronous). After release, a tie is granted to requester 0.
- ALU_ARB_FIXED_PRIO_EN build: both requesters continuously valid for 4 operations -> all 4 grants go to requester 0. In the default build, grants go 0,1,0,1.
- Wrap result: ADD a=32'hFFFF_FFFF, b=1 -> resp_data=0. SUB a=0, b=1 -> resp_data=32'hFFFF_FFFF.
